// File: rtl/snd_axi_pkg.sv
// snd_axi_pkg: AXI response codes, responder state encoding and default sample-memory base
package snd_axi_pkg;
    localparam logic [1:0] RRESP_OKAY = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [31:0] SND_BASE_ADDR = 32'(3'b010) << 28;
    typedef enum logic [1:0] {S_IDLE, S_LAT, S_DATA} rd_state_t;
endpackage

// File: rtl/snd_resp_ram.sv
// snd_resp_ram: simple dual-port RAM, read-first, one-cycle read latency
module snd_resp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              ACLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge ACLK) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/snd_axi_rdresp.sv
// snd_axi_rdresp: AXI INCR burst read responder over a preloadable on-chip sample RAM
module snd_axi_rdresp
    import snd_axi_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = SND_BASE_ADDR,
    parameter int          LATENCY   = 2
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic [31:0]       ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    input  logic              WR_EN,
    input  logic [MEM_AW-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic [15:0]       BURST_CNT
);
    localparam int BYTES = DATA_W / 8;
    localparam int SH = $clog2(BYTES);
    localparam logic [32:0] SPAN = 33'(BYTES) << MEM_AW;
    rd_state_t state, state_nx;
    logic [7:0] lat_cnt, len, beat;
    logic [MEM_AW-1:0] idx, rd_addr;
    logic [DATA_W-1:0] ram_q, hold, cur;
    logic [31:0] off;
    logic err, fresh, ar_hs, r_hs, last, lat_done;
    assign off = ARADDR - BASE_ADDR;
    assign ar_hs = ARVALID & ARREADY;
    assign r_hs = (state == S_DATA) & RREADY;
    assign last = beat == len;
    assign lat_done = lat_cnt == 8'(LATENCY - 1);
    // On a handshake fetch the following word so the next beat is ready back-to-back
    assign rd_addr = r_hs ? idx + MEM_AW'(1) : idx;
    // Stalled beats replay the held copy so a concurrent preload cannot disturb them
    assign cur = fresh ? ram_q : hold;
    snd_resp_ram #(.DATA_W(DATA_W), .ADDR_W(MEM_AW)) u_ram (
        .ACLK    (ACLK),
        .we      (WR_EN),
        .wr_addr (WR_ADDR),
        .wr_data (WR_DATA),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );
    always_ff @(posedge ACLK) state <= ARST ? S_IDLE : state_nx;
    always_comb begin
        state_nx = state;
        RVALID = state == S_DATA;
        RLAST = state == S_DATA && last;
        RRESP = state == S_DATA && err ? RRESP_SLVERR : RRESP_OKAY;
        RDATA = state == S_DATA && !err ? cur : '0;
        case (state)
            S_IDLE:  if (ar_hs) state_nx = S_LAT;
            S_LAT:   if (lat_done) state_nx = S_DATA;
            S_DATA:  if (r_hs && last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            ARREADY <= 1'b0;
            fresh <= 1'b0;
            BURST_CNT <= '0;
        end else begin
            ARREADY <= state_nx == S_IDLE;
            fresh <= (state == S_LAT && lat_done) || r_hs;
            if (r_hs && last) BURST_CNT <= BURST_CNT + 16'd1;
        end
        hold <= cur;
        if (ar_hs) begin
            idx <= MEM_AW'(off >> SH);
            len <= ARLEN;
            beat <= '0;
            lat_cnt <= '0;
            err <= ARADDR < BASE_ADDR || {1'b0, off} >= SPAN;
        end else begin
            if (state == S_LAT) lat_cnt <= lat_cnt + 8'd1;
            if (r_hs) begin
                idx <= idx + MEM_AW'(1);
                beat <= beat + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_snd_axi_rdresp.sv
// tb_snd_axi_rdresp: scoreboard bench for the AXI burst read responder
module tb_snd_axi_rdresp;
    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int LAT = 2;
    localparam int DEPTH = 4096;

    logic ACLK = 1'b0, ARST = 1'b1;
    logic [31:0] ARADDR = '0;
    logic [7:0] ARLEN = '0;
    logic ARVALID = 1'b0, ARREADY, RLAST, RVALID, RREADY = 1'b0, WR_EN = 1'b0;
    logic [31:0] RDATA, WR_DATA = '0;
    logic [1:0] RRESP;
    logic [11:0] WR_ADDR = '0;
    logic [15:0] BURST_CNT;

    snd_axi_rdresp dut (
        .ACLK(ACLK), .ARST(ARST), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID),
        .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .BURST_CNT(BURST_CNT)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {logic [31:0] d; logic [1:0] r; logic l;} beat_t;
    beat_t q[$];
    beat_t e, prev;
    logic [31:0] tbm [DEPTH];
    int checks = 0, errors = 0, cyc = 0, first_cyc = 0, beats = 0, exp_bursts = 0, rmode = 0;
    bit busy = 0, pend = 0, after_last = 0, stall_prev = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, x, cyc);
        end
    endtask

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    initial forever begin
        @(posedge ACLK);
        #1;
        RREADY = rmode == 0 ? 1'b1 : rmode == 1 ? ~RREADY : 1'($urandom % 2);
    end

    // Reference: a burst is ARLEN+1 words from (addr-BASE)/4 modulo depth, or zeros with SLVERR
    task automatic push_burst(input logic [31:0] a, input logic [7:0] l);
        longint unsigned aa = a;
        bit inr = aa >= BASE && aa < BASE + 4 * DEPTH;
        longint unsigned w0 = inr ? (aa - BASE) / 4 : 0;
        for (int k = 0; k <= l; k++)
            q.push_back('{inr ? tbm[(w0 + k) % DEPTH] : 32'h0, inr ? 2'b00 : 2'b10, k == l});
    endtask

    initial forever begin
        @(negedge ACLK);
        if (ARST) begin
            q.delete();
            busy = 0; pend = 0; after_last = 0; stall_prev = 0; exp_bursts = 0;
        end else begin
            chk("burst_cnt", 32'(BURST_CNT), exp_bursts);
            if (after_last) chk("arready_after_last", 32'(ARREADY), 1);
            else if (busy) chk("arready_busy", 32'(ARREADY), 0);
            after_last = 0;
            if (stall_prev) begin
                chk("stall_rvalid", 32'(RVALID), 1);
                chk("stall_rdata", RDATA, prev.d);
                chk("stall_rresp", 32'(RRESP), 32'(prev.r));
                chk("stall_rlast", 32'(RLAST), 32'(prev.l));
            end
            if (pend && RVALID) begin
                chk("first_rvalid_cycle", cyc, first_cyc);
                pend = 0;
            end
            if (RVALID && RREADY) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got %h expected no beat", RDATA);
                end else begin
                    e = q.pop_front();
                    chk("rdata", RDATA, e.d);
                    chk("rresp", 32'(RRESP), 32'(e.r));
                    chk("rlast", 32'(RLAST), 32'(e.l));
                    beats++;
                    if (e.l) begin
                        exp_bursts = (exp_bursts + 1) % 65536;
                        after_last = 1;
                        busy = 0;
                    end
                end
            end
            stall_prev = RVALID && !RREADY;
            prev = '{RDATA, RRESP, RLAST};
            if (ARVALID && ARREADY) begin
                push_burst(ARADDR, ARLEN);
                busy = 1; pend = 1; beats = 0;
                first_cyc = cyc + 1 + LAT;
            end
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        WR_EN = 1; WR_ADDR = 12'(a); WR_DATA = d;
        tbm[a] = d;
        @(posedge ACLK);
        #1;
        WR_EN = 0;
    endtask

    task automatic ar(input logic [31:0] a, input logic [7:0] l);
        ARADDR = a; ARLEN = l; ARVALID = 1;
        for (int i = 0; i < 600; i++) begin
            @(negedge ACLK);
            if (ARREADY) begin
                @(posedge ACLK);
                #1;
                ARVALID = 0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL ar_timeout: got no ARREADY expected ARREADY within 600 cycles");
        ARVALID = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(posedge ACLK);
            #1;
            if (!busy) return;
        end
        checks++; errors++;
        $display("FAIL idle_timeout: got busy expected idle within 3000 cycles");
    endtask

    initial begin
        logic [31:0] a;
        int sel;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_arready", 32'(ARREADY), 0);
        chk("rst_rvalid", 32'(RVALID), 0);
        chk("rst_rlast", 32'(RLAST), 0);
        chk("rst_rresp", 32'(RRESP), 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_burst_cnt", 32'(BURST_CNT), 0);
        ARST = 0;
        @(posedge ACLK);
        #1;
        chk("arready_after_rst", 32'(ARREADY), 1);
        for (int i = 0; i < DEPTH; i++) wr(i, $urandom);
        for (int i = 0; i < 32; i++) wr(i, 32'(i) * 32'h0101_0101);
        rmode = 0;
        ar(BASE, 8'd31);
        wait_idle();
        rmode = 1;
        ar(BASE, 8'd31);
        wait_idle();
        rmode = 0;
        wr(4095, 32'hAAAA_AAAA);
        wr(0, 32'h5555_5555);
        ar(32'h2000_3FFC, 8'd1);
        wait_idle();
        ar(32'h1000_0000, 8'd3);
        wait_idle();
        ar(32'h2000_4000, 8'd0);
        wait_idle();
        ar(32'h2000_3FFF, 8'd0);
        wait_idle();
        ar(BASE + 32'h10, 8'd7);
        ar(BASE + 32'h100, 8'd2);
        wait_idle();
        ar(BASE, 8'd31);
        for (int i = 0; i < 200 && beats < 5; i++) begin
            @(posedge ACLK);
            #1;
        end
        ARST = 1;
        @(posedge ACLK);
        #1;
        ARST = 0;
        chk("midrst_rvalid", 32'(RVALID), 0);
        chk("midrst_arready", 32'(ARREADY), 0);
        chk("midrst_burst_cnt", 32'(BURST_CNT), 0);
        @(posedge ACLK);
        #1;
        chk("midrst_arready_after", 32'(ARREADY), 1);
        ar(BASE + 32'h40, 8'd3);
        wait_idle();
        rmode = 2;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom % 8);
            a = sel == 0 ? BASE - 32'(4 * (1 + $urandom % 16)) :
                sel == 1 ? BASE + 32'h4000 + 32'($urandom % 64) :
                BASE + 32'($urandom % 32'h4000);
            if (n % 4 == 0) wr(int'($urandom % DEPTH), $urandom);
            ar(a, 8'($urandom % 16));
            wait_idle();
        end
        repeat (3) @(posedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before 900000");
        $fatal(1, "watchdog");
    end
endmodule
